// File: rtl/ecc_apb_stim_master.sv
// APB stimulus requester for the ECC register file: four writes, wait for done, one readback, one response.
// Optional WAIT_DONE timeout is compiled in by defining ECC_STIM_TIMEOUT_EN.
module ecc_apb_stim_master #(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int DATA_WIDTH      = 32,
   parameter int TIMEOUT         = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [AMBA_WORD-1:0]       cmd_data,
   input  logic [1:0]                 cmd_width,
   input  logic [AMBA_WORD-1:0]       cmd_noise,
   input  logic [AMBA_ADDR_WIDTH-1:0] cmd_rd_addr,
   output logic                       psel,
   output logic                       penable,
   output logic                       pwrite,
   output logic [AMBA_ADDR_WIDTH-1:0] paddr,
   output logic [AMBA_WORD-1:0]       pwdata,
   input  logic [AMBA_WORD-1:0]       prdata,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      data_out,
   input  logic [1:0]                 num_of_errors,
   output logic                       rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_data_out,
   output logic [1:0]                 rsp_num_err,
   output logic [AMBA_WORD-1:0]       rsp_rdata,
   output logic                       rsp_timeout
);

   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL    = AMBA_ADDR_WIDTH'(32'h00);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN = AMBA_ADDR_WIDTH'(32'h04);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW      = AMBA_ADDR_WIDTH'(32'h08);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE   = AMBA_ADDR_WIDTH'(32'h0C);

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("ecc_apb_stim_master: TIMEOUT must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_ACCESS,
      WAIT_DONE,
      R_SETUP,
      R_ACCESS,
      RESP
   } state_t;

   state_t                     state, state_nxt;
   logic [1:0]                 idx;
   logic [1:0]                 op_q, width_q;
   logic [AMBA_WORD-1:0]       data_q, noise_q;
   logic [AMBA_ADDR_WIDTH-1:0] rd_addr_q;
   logic [DATA_WIDTH-1:0]      cap_data;
   logic [1:0]                 cap_err;
   logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
   logic [AMBA_WORD-1:0]       wr_data;
   logic                       timed_out;

   // Write order is DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL last so the start comes after setup.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      wr_addr = ADDR_CTRL;
      wr_data = AMBA_WORD'(op_q);
      case (idx)
         2'd0: begin
            wr_addr = ADDR_DATA_IN;
            wr_data = data_q;
         end
         2'd1: begin
            wr_addr = ADDR_CW;
            wr_data = AMBA_WORD'(width_q);
         end
         2'd2: begin
            wr_addr = ADDR_NOISE;
            wr_data = noise_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      pwrite    = 1'b0;
      paddr     = '0;
      pwdata    = '0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = W_SETUP;
         end
         W_SETUP: begin
            psel      = 1'b1;
            pwrite    = 1'b1;
            paddr     = wr_addr;
            pwdata    = wr_data;
            state_nxt = W_ACCESS;
         end
         W_ACCESS: begin
            psel      = 1'b1;
            penable   = 1'b1;
            pwrite    = 1'b1;
            paddr     = wr_addr;
            pwdata    = wr_data;
            state_nxt = (idx == 2'd3) ? WAIT_DONE : W_SETUP;
         end
         WAIT_DONE: begin
            if (operation_done)  state_nxt = R_SETUP;
            else if (timed_out)  state_nxt = RESP;
         end
         R_SETUP: begin
            psel      = 1'b1;
            paddr     = rd_addr_q;
            state_nxt = R_ACCESS;
         end
         R_ACCESS: begin
            psel      = 1'b1;
            penable   = 1'b1;
            paddr     = rd_addr_q;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: all storage, including latched command fields, is reset so outputs are 0 the moment rst falls.
      if (!rst) begin
         state        <= IDLE;
         idx          <= '0;
         op_q         <= '0;
         width_q      <= '0;
         data_q       <= '0;
         noise_q      <= '0;
         rd_addr_q    <= '0;
         cap_data     <= '0;
         cap_err      <= '0;
         rsp_data_out <= '0;
         rsp_num_err  <= '0;
         rsp_rdata    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         state <= state_nxt;
         case (state)
            IDLE: if (cmd_valid) begin
               idx       <= '0;
               op_q      <= cmd_op;
               width_q   <= cmd_width;
               data_q    <= cmd_data;
               noise_q   <= cmd_noise;
               rd_addr_q <= cmd_rd_addr;
            end
            W_ACCESS: if (idx != 2'd3) idx <= idx + 2'd1;
            WAIT_DONE: if (operation_done) begin
               cap_data <= data_out;
               cap_err  <= num_of_errors;
            end
            R_ACCESS: begin
               rsp_data_out <= cap_data;
               rsp_num_err  <= cap_err;
               rsp_rdata    <= prdata;
            end
            default: ;
         endcase
         // Response fields only change as RESP is entered, so they hold between responses.
         if (timed_out) begin
            rsp_data_out <= '0;
            rsp_num_err  <= '0;
            rsp_rdata    <= '0;
         end
      end
   end

`ifdef ECC_STIM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wait_cnt;
   logic          timeout_q;

   // Counter is zero on entry to WAIT_DONE; the last allowed cycle is the one holding TIMEOUT-1.
   assign timed_out = (state == WAIT_DONE) && !operation_done &&
                      (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == WAIT_DONE) wait_cnt <= wait_cnt + CW'(1);
         else                    wait_cnt <= '0;
         if (timed_out)               timeout_q <= 1'b1;
         else if (state == R_ACCESS)  timeout_q <= 1'b0;
      end
   end

   assign rsp_timeout = timeout_q;
`else
   assign timed_out   = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/ecc_apb_stim_master.md
# ecc_apb_stim_master

APB requester that drives the ECC encoder/decoder register file from a simple command port, then waits for the result and reads back one register. It is the stimulus end of the verification environment and the counterpart of the result checker. It accepts one command, issues four APB writes (DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL to start), waits for `operation_done`, captures `data_out`/`num_of_errors`, performs one APB read, and returns everything on a single response pulse.

## Interface
- `AMBA_WORD`, 32, APB data bus width.
- `AMBA_ADDR_WIDTH`, 20, APB address width.
- `DATA_WIDTH`, 32, width of the DUT `data_out`.
- `TIMEOUT`, 1024, maximum WAIT_DONE cycles; used only with the timeout feature.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  2  value written to CTRL.
- `cmd_data`  in  AMBA_WORD  value written to DATA_IN.
- `cmd_width`  in  2  value written to CODEWORD_WIDTH (zero-extended).
- `cmd_noise`  in  AMBA_WORD  value written to NOISE.
- `cmd_rd_addr`  in  AMBA_ADDR_WIDTH  address of the readback access.
- `psel`, `penable`, `pwrite`  out  1 each  APB controls.
- `paddr`  out  AMBA_ADDR_WIDTH  APB address.
- `pwdata`  out  AMBA_WORD  APB write data.
- `prdata`  in  AMBA_WORD  APB read data.
- `operation_done`  in  1  DUT completion flag.
- `data_out`  in  DATA_WIDTH  DUT result.
- `num_of_errors`  in  2  DUT error count.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_data_out`  out  DATA_WIDTH  captured `data_out`.
- `rsp_num_err`  out  2  captured `num_of_errors`.
- `rsp_rdata`  out  AMBA_WORD  captured `prdata` from the readback.
- `rsp_timeout`  out  1  the operation timed out.

## Operation
- Register offsets, zero-extended to AMBA_ADDR_WIDTH:
  - CTRL 0x00
  - DATA_IN 0x04
  - CODEWORD_WIDTH 0x08
  - NOISE 0x0C
- FSM states: IDLE, W_SETUP, W_ACCESS, WAIT_DONE, R_SETUP, R_ACCESS, RESP.
- A 2-bit write index selects the write address and data, in the order DATA_IN, CODEWORD_WIDTH, NOISE, CTRL.
- IDLE: `cmd_ready`=1. When `cmd_valid` is high, latch all `cmd_*` fields, clear the index, and go to W_SETUP.
- W_SETUP: `psel`=1, `penable`=0, `pwrite`=1, address and data from the index. Next state W_ACCESS.
- W_ACCESS: `penable`=1, other APB outputs held. No wait states.
  - Index < 3: increment the index and go to W_SETUP; `psel` stays high.
  - Index = 3: go to WAIT_DONE.
- WAIT_DONE: `psel`=0, `penable`=0. When `operation_done` is sampled high, capture `data_out` and `num_of_errors`, then go to R_SETUP.
- R_SETUP / R_ACCESS: APB read of `cmd_rd_addr` with `pwrite`=0. `prdata` is captured at the rising edge that ends R_ACCESS. Next state RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- `rsp_*` data outputs hold their values until the next RESP.
- `operation_done` is ignored outside WAIT_DONE.
- `cmd_valid` is ignored outside IDLE; no queuing.
- `pwdata` and `paddr` are driven to 0 whenever `psel`=0.
- Reset, asynchronous and possibly mid-operation: state goes to IDLE and every output goes to 0 immediately, except `cmd_ready`, which goes to 1. The in-flight command is dropped.

## Timing
- Command accepted at edge T0; W_SETUP is the cycle after T0.
- Writes occupy 8 cycles, T1–T8; the CTRL access phase is T8.
- WAIT_DONE lasts at least 1 cycle. If `operation_done` is high at its first sample, R_SETUP is T10.
- R_SETUP T10, R_ACCESS T11, RESP T12. Minimum command-to-`rsp_valid` latency is 12 cycles.
- The next command can be accepted one cycle after RESP.

## Configuration
- Macro `ECC_STIM_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - When it reaches TIMEOUT with `operation_done` still low, the FSM skips the readback and goes straight to RESP.
  - That RESP drives `rsp_timeout`=1 and `rsp_data_out`, `rsp_num_err`, `rsp_rdata` = 0.
  - If `operation_done` and the terminal count occur in the same cycle, completion wins: `rsp_timeout`=0.
- Undefined: WAIT_DONE waits indefinitely, `rsp_timeout` is tied to 0, and no counter is synthesised.

## Test plan
- Reset value check: assert `rst`=0 mid-W_ACCESS -> `psel`, `penable`, `rsp_valid` = 0 in the same cycle, `cmd_ready`=1. After release, a new command completes normally.
- Write sequence: `cmd_data`=0xA5, `cmd_width`=0, `cmd_noise`=0x1, `cmd_op`=2 -> four writes, addresses 0x04/0x08/0x0C/0x00 with data 0xA5/0/0x1/2, each SETUP then ACCESS with back-to-back `psel`.
- Completion: `operation_done` pulsed 5 cycles after CTRL with `data_out`=0xA5 and `num_of_errors`=1, `prdata`=0xA5 at `cmd_rd_addr`=0x04 -> `rsp_valid` one cycle with 0xA5 / 1 / 0xA5.
- Ignore rules: `operation_done` high during the writes, and `cmd_valid` held high throughout -> no early capture, and exactly one command is accepted per RESP→IDLE.
- Timeout, with `ECC_STIM_TIMEOUT_EN` and TIMEOUT=16: `operation_done` never asserted -> RESP 16 cycles after entering WAIT_DONE with `rsp_timeout`=1 and no APB read issued.
- Tie, with `ECC_STIM_TIMEOUT_EN`: `operation_done` on the terminal count cycle -> readback occurs and `rsp_timeout`=0.
